// File: rtl/pwm_compare_gen.sv
// pwm_compare_gen: registered PWM from an external free-running counter, with a
// handshaked shadow duty that only takes effect on period boundaries.
module pwm_compare_gen #(
   parameter int CNT_W = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             run,
   input  logic [CNT_W:0]   duty_in,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_out,
   output logic             period_done,
   output logic             busy
);
   localparam logic [CNT_W:0] FULL = (CNT_W+1)'(1) << CNT_W;
   typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;
   state_t r_state, w_next;
   logic [CNT_W:0] r_duty_act, r_duty_shd, w_clamp;
   logic r_pending, r_pwm, r_period_done;
   logic w_max, w_active, w_accept, w_boundary;
   assign w_max      = &cnt_in;
   assign w_boundary = (r_state == IDLE) | w_max;
   assign w_accept   = duty_valid & duty_ready;
   assign w_clamp    = duty_in > FULL ? FULL : duty_in;
   assign pwm_out     = r_pwm;
   assign period_done = r_period_done;
   always_ff @(posedge Clk)
      if (Reset) r_state <= IDLE;
      else       r_state <= w_next;
   // In DRAIN a re-raised run takes priority over finishing at MAX.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = run ? ARMED : IDLE;
         ARMED:   w_next = w_max ? (run ? RUN : IDLE) : ARMED;
         RUN:     w_next = run ? RUN : (w_max ? IDLE : DRAIN);
         DRAIN:   w_next = run ? RUN : (w_max ? IDLE : DRAIN);
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      w_active   = (r_state == RUN) | (r_state == DRAIN);
      busy       = r_state != IDLE;
      duty_ready = ~r_pending & ~Reset;
   end
   always_ff @(posedge Clk)
      if (Reset) begin
         r_duty_act    <= '0;
         r_duty_shd    <= '0;
         r_pending     <= 1'b0;
         r_pwm         <= 1'b0;
         r_period_done <= 1'b0;
      end else begin
         if (w_boundary & r_pending) begin
            r_duty_act <= r_duty_shd;
            r_pending  <= 1'b0;
         end
         if (w_accept) begin
            r_duty_shd <= w_clamp;
            r_pending  <= 1'b1;
         end
         r_pwm         <= w_active & ({1'b0, cnt_in} < r_duty_act);
         r_period_done <= w_active & w_max;
      end
endmodule

// File: tb/tb_pwm_compare_gen.sv
// tb_pwm_compare_gen: cycle model scoreboard plus per-period high-count scoreboard
// for pwm_compare_gen driven by a bench-side 4-bit counter.
module tb_pwm_compare_gen;
   logic Clk, Reset, run, duty_valid;
   logic [3:0] cnt_in;
   logic [4:0] duty_in;
   logic duty_ready, pwm_out, period_done, busy;
   typedef struct packed {logic pwm; logic pd; logic busy;} exp_t;
   exp_t sb[$];
   int per_q[$];
   int checks = 0, errors = 0;
   int m_state = 0, m_act = 0, m_shd = 0, n_pd = 0, acc_h = 0;
   bit m_pend = 0;
   int v[5] = '{5, 12, 17, 1, 9};

   pwm_compare_gen #(.CNT_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .cnt_in(cnt_in), .run(run), .duty_in(duty_in),
      .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm_out(pwm_out),
      .period_done(period_done), .busy(busy)
   );

   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h cnt_in=%0d t=%0t", tag, obs, exp, cnt_in, $time);
      end
   endtask

   // One clock: predict outputs from the spec model, advance, compare.
   task automatic tick();
      exp_t e;
      int ns, nact, nshd, ex;
      bit npend, mx, act, acc;
      mx = cnt_in == 4'd15;
      act = m_state >= 2;
      acc = duty_valid && !m_pend && !Reset;
      e.pwm = !Reset && act && (int'(cnt_in) < m_act);
      e.pd = !Reset && act && mx;
      ns = m_state; nact = m_act; nshd = m_shd; npend = m_pend;
      if (Reset) begin
         ns = 0; nact = 0; nshd = 0; npend = 0;
      end else begin
         case (m_state)
            0: ns = run ? 1 : 0;
            1: ns = mx ? (run ? 2 : 0) : 1;
            default: ns = run ? 2 : (mx ? 0 : 3);
         endcase
         if ((m_state == 0 || mx) && m_pend) begin nact = m_shd; npend = 0; end
         if (acc) begin nshd = int'(duty_in) > 16 ? 16 : int'(duty_in); npend = 1; end
      end
      e.busy = ns != 0;
      sb.push_back(e);
      @(posedge Clk); #1;
      m_state = ns; m_act = nact; m_shd = nshd; m_pend = npend;
      cnt_in = Reset ? 4'd0 : cnt_in + 4'd1;
      e = sb.pop_front();
      chk("pwm_out", pwm_out, e.pwm);
      chk("period_done", period_done, e.pd);
      chk("busy", busy, e.busy);
      chk("duty_ready", duty_ready, !m_pend && !Reset);
      if (Reset) acc_h = 0;
      else begin
         acc_h += int'(pwm_out);
         if (period_done) begin
            n_pd++;
            ex = per_q.size() != 0 ? per_q.pop_front() : -1;
            chk("period_highs", acc_h, ex);
            acc_h = 0;
         end
      end
   endtask

   task automatic wait_cnt(int t);
      int n = 0;
      while (int'(cnt_in) != t && n < 40) begin tick(); n++; end
      if (n == 40) begin errors++; $error("FAIL wait_cnt timeout observed=%0d expected=%0d", cnt_in, t); end
   endtask

   task automatic run_periods(int n);
      int tgt = n_pd + n, b = 0;
      while (n_pd < tgt && b < 20 * n + 40) begin tick(); b++; end
      if (n_pd < tgt) begin errors++; $error("FAIL period_timeout observed=%0d expected=%0d", n_pd, tgt); end
   endtask

   task automatic load(int d);
      duty_in = 5'(d);
      duty_valid = 1;
      tick();
      duty_valid = 0;
   endtask

   initial begin
      Reset = 1; run = 0; duty_valid = 0; duty_in = 0; cnt_in = 0;
      tick(); tick();
      chk("reset_ready", duty_ready, 0);
      Reset = 0;
      // T1: duty 4 loaded in IDLE
      load(4);
      per_q = '{4, 4, 4};
      run = 1;
      run_periods(3);
      // T2: clamp 20 -> 16, then 0
      per_q = '{4, 16, 16};
      load(20);
      run_periods(3);
      per_q = '{16, 0, 0};
      load(0);
      run_periods(3);
      // T3: mid-period update applies at next period only
      per_q = '{0, 8};
      load(8);
      run_periods(2);
      per_q = '{8, 3};
      wait_cnt(5);
      load(3);
      chk("t3_ready_low", duty_ready, 0);
      run_periods(2);
      // T4: drain to IDLE, then drop/re-raise without a gap
      per_q = '{3};
      wait_cnt(6);
      run = 0;
      run_periods(1);
      repeat (3) tick();
      chk("t4_idle_busy", busy, 0);
      per_q = '{3, 3};
      run = 1;
      run_periods(1);
      wait_cnt(6);
      run = 0;
      wait_cnt(9);
      chk("t4_drain_busy", busy, 1);
      run = 1;
      run_periods(1);
      // T5: reset mid-run with a pending duty
      wait_cnt(7);
      load(9);
      wait_cnt(10);
      Reset = 1;
      tick();
      chk("t5_pwm", pwm_out, 0);
      chk("t5_busy", busy, 0);
      Reset = 0;
      #1;
      chk("t5_ready", duty_ready, 1);
      per_q = '{0};
      run_periods(1);
      // T6: duty_valid held high, one accept per boundary
      for (int j = 0; j < 5; j++) begin
         per_q.push_back(j == 0 ? 0 : (v[j-1] > 16 ? 16 : v[j-1]));
         repeat (16) begin
            duty_valid = 1;
            duty_in = cnt_in == 4'd0 ? 5'(v[j]) : 5'(31 - int'(cnt_in));
            tick();
         end
      end
      duty_valid = 0;
      per_q.push_back(9);
      run = 0;
      run_periods(1);
      repeat (4) tick();
      chk("periods_left", per_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
